// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game sequencer
// Purpose: state encoding, datapath widths and the saturating score helper.
// Ports: none (package).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUNNING   = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    localparam int SCORE_W  = 14;
    localparam int PERIOD_W = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'h3FFF;

    // Score sticks at its maximum instead of wrapping to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - player-side inputs and timing outputs of the sequencer
// Purpose: bundles the button/crash inputs and all tick, pulse and status outputs.
// Ports: master drives start_btn/crash and observes the rest; slave is the sequencer.
interface game_sequencer_if;
    import game_pkg::*;

    logic                start_btn;
    logic                crash;
    logic [1:0]          game_tick;
    logic                debounce_en;
    logic                game_start_pulse;
    logic                game_over_pulse;
    logic                running;
    logic [PERIOD_W-1:0] scroll_period;
    logic [SCORE_W-1:0]  score;

    modport master (
        output start_btn, crash,
        input  game_tick, debounce_en, game_start_pulse, game_over_pulse,
        input  running, scroll_period, score
    );

    modport slave (
        input  start_btn, crash,
        output game_tick, debounce_en, game_start_pulse, game_over_pulse,
        output running, scroll_period, score
    );

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running modulo-DIV counter with terminal-count decode
// Purpose: counts 0..DIV-1 forever; tick is high while the count sits at DIV-1.
// Ports: clk, reset (sync, active-high), tick (terminal-count flag).
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int               CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pure decode of the counter register. The sequencer registers it, so the
    // visible pulse lands in the cycle after the count reaches DIV-1, while the
    // sequencer can still act on the same edge that raises that pulse.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game-flow FSM, scroll/speed/lockout counters and score
// Purpose: sequences IDLE/RUNNING/GAME_OVER, generates frame/scroll ticks and the
//          debounce strobe, and keeps the run score.
// Ports: clk, reset (sync, active-high), bus (game_sequencer_if.slave):
//        start_btn/crash in; game_tick, debounce_en, game_start_pulse,
//        game_over_pulse, running, scroll_period, score out (all registered).
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAME_DIV      = 200000,
    parameter int DEBOUNCE_DIV   = 50000,
    parameter int BASE_PERIOD    = 8,
    parameter int MIN_PERIOD     = 2,
    parameter int SPEEDUP_TICKS  = 64,
    parameter int LOCKOUT_FRAMES = 60
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);

    localparam int SPD_W = $clog2(SPEEDUP_TICKS + 1);
    localparam int LCK_W = $clog2(LOCKOUT_FRAMES + 1);

    localparam logic [PERIOD_W-1:0] BASE     = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] MINP     = PERIOD_W'(MIN_PERIOD);
    localparam logic [SPD_W-1:0]    SPD_LAST = SPD_W'(SPEEDUP_TICKS - 1);
    localparam logic [LCK_W-1:0]    LCK_LAST = LCK_W'(LOCKOUT_FRAMES - 1);

    game_state_t state, next_state;

    logic frame_pre, deb_pre;

    // Inputs are registered once; the edge detector compares that sample with
    // the one before it.
    logic btn_q, btn_prev, crash_q;

    logic                frame_q, deb_q, scroll_q;
    logic                start_q, over_q, running_q;
    logic [PERIOD_W-1:0] scroll_cnt, period_q;
    logic [SPD_W-1:0]    speed_cnt;
    logic [LCK_W-1:0]    lock_cnt;
    logic [SCORE_W-1:0]  score_q;

    logic start_edge;
    logic start_d, over_d, frame_adv, scroll_d;

    tick_divider #(.DIV(FRAME_DIV)) u_frame_div (
        .clk   (clk),
        .reset (reset),
        .tick  (frame_pre)
    );

    tick_divider #(.DIV(DEBOUNCE_DIV)) u_debounce_div (
        .clk   (clk),
        .reset (reset),
        .tick  (deb_pre)
    );

    assign start_edge = btn_q & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_edge) next_state = RUNNING;
            RUNNING:   if (crash_q) next_state = GAME_OVER;
            // frame_q is the frame tick currently visible on the output.
            GAME_OVER: if (frame_q && lock_cnt == LCK_LAST) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        start_d   = (state == IDLE) && (next_state == RUNNING);
        over_d    = (state == RUNNING) && (next_state == GAME_OVER);
        // A crash on the deciding edge freezes the run: no frame advance,
        // no scroll tick, no score.
        frame_adv = (state == RUNNING) && !crash_q && frame_pre;
        scroll_d  = frame_adv && (scroll_cnt == period_q - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q      <= 1'b0;
            btn_prev   <= 1'b0;
            crash_q    <= 1'b0;
            frame_q    <= 1'b0;
            deb_q      <= 1'b0;
            scroll_q   <= 1'b0;
            start_q    <= 1'b0;
            over_q     <= 1'b0;
            running_q  <= 1'b0;
            scroll_cnt <= '0;
            speed_cnt  <= '0;
            lock_cnt   <= '0;
            period_q   <= BASE;
            score_q    <= '0;
        end else begin
            btn_q     <= bus.start_btn;
            btn_prev  <= btn_q;
            crash_q   <= bus.crash;
            frame_q   <= frame_pre;
            deb_q     <= deb_pre;
            scroll_q  <= scroll_d;
            start_q   <= start_d;
            over_q    <= over_d;
            running_q <= (next_state == RUNNING);

            if (start_d) begin
                score_q    <= '0;
                period_q   <= BASE;
                scroll_cnt <= '0;
                speed_cnt  <= '0;
            end else if (frame_adv) begin
                if (scroll_d) begin
                    scroll_cnt <= '0;
                    score_q    <= score_inc(score_q);
                    if (speed_cnt == SPD_LAST) begin
                        speed_cnt <= '0;
                        if (period_q > MINP) begin
                            period_q <= period_q - 1'b1;
                        end
                    end else begin
                        speed_cnt <= speed_cnt + 1'b1;
                    end
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end

            if (over_d) begin
                lock_cnt <= '0;
            end else if (state == GAME_OVER && frame_q) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    assign bus.game_tick        = {frame_q, scroll_q};
    assign bus.debounce_en      = deb_q;
    assign bus.game_start_pulse = start_q;
    assign bus.game_over_pulse  = over_q;
    assign bus.running          = running_q;
    assign bus.scroll_period    = period_q;
    assign bus.score            = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam int FD     = 4;
    localparam int DD     = 6;
    localparam int BASE   = 3;
    localparam int MINP   = 2;
    localparam int SPD    = 2;
    localparam int LOCK   = 2;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_OVER = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    game_sequencer_if bus();

    game_sequencer #(
        .FRAME_DIV      (FD),
        .DEBOUNCE_DIV   (DD),
        .BASE_PERIOD    (BASE),
        .MIN_PERIOD     (MINP),
        .SPEEDUP_TICKS  (SPD),
        .LOCKOUT_FRAMES (LOCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles since reset, game phase, ticks survived this run,
    // frames since the last scroll tick, lockout frames seen.
    int cyc     = 0;
    int m_st    = S_IDLE;
    int m_score = 0;
    int m_ticks = 0;
    int m_fcnt  = 0;
    int m_lock  = 0;
    bit m_bs = 0, m_bp = 0, m_cs = 0;
    bit e_frame = 0, e_deb = 0, e_scroll = 0, e_start = 0, e_over = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int m_period();
        int p;
        p = BASE - m_ticks / SPD;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_edge();
        bit prev_frame;
        if (reset) begin
            cyc = 0; m_st = S_IDLE; m_score = 0; m_ticks = 0; m_fcnt = 0; m_lock = 0;
            m_bs = 0; m_bp = 0; m_cs = 0;
            e_frame = 0; e_deb = 0; e_scroll = 0; e_start = 0; e_over = 0;
        end else begin
            prev_frame = e_frame;
            cyc++;
            e_frame  = (cyc % FD == 0);
            e_deb    = (cyc % DD == 0);
            e_scroll = 0; e_start = 0; e_over = 0;
            case (m_st)
                S_IDLE: if (m_bs && !m_bp) begin
                    m_st = S_RUN; m_score = 0; m_ticks = 0; m_fcnt = 0; e_start = 1;
                end
                S_RUN: if (m_cs) begin
                    m_st = S_OVER; m_lock = 0; e_over = 1;
                end else if (e_frame) begin
                    m_fcnt++;
                    if (m_fcnt == m_period()) begin
                        m_fcnt = 0; e_scroll = 1; m_ticks++;
                        if (m_score < 16383) m_score++;
                    end
                end
                default: if (prev_frame) begin
                    m_lock++;
                    if (m_lock == LOCK) m_st = S_IDLE;
                end
            endcase
            m_bp = m_bs;
            m_bs = bus.start_btn;
            m_cs = bus.crash;
        end
    endtask

    task automatic check_all();
        check("frame_tick",  32'(bus.game_tick[1]),     32'(e_frame));
        check("scroll_tick", 32'(bus.game_tick[0]),     32'(e_scroll));
        check("debounce_en", 32'(bus.debounce_en),      32'(e_deb));
        check("start_pulse", 32'(bus.game_start_pulse), 32'(e_start));
        check("over_pulse",  32'(bus.game_over_pulse),  32'(e_over));
        check("running",     32'(bus.running),          32'(m_st == S_RUN));
        check("period",      32'(bus.scroll_period),    32'(m_period()));
        check("score",       32'(bus.score),            32'(m_score));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit b, input bit c);
        bus.start_btn = b;
        bus.crash     = c;
    endtask

    initial begin
        int nf, nd, saved;
        bit b;
        drive(0, 0);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        nf = 0; nd = 0;
        repeat (24) begin
            step();
            nf += int'(bus.game_tick[1]);
            nd += int'(bus.debounce_en);
        end
        check("idle_frame_count", 32'(nf), 32'd6);
        check("idle_deb_count",   32'(nd), 32'd4);

        drive(1, 0);
        step(); step();
        check("start_pulse_seen", 32'(bus.game_start_pulse), 32'd1);
        check("start_running",    32'(bus.running),          32'd1);

        for (int i = 0; i < 400 && m_ticks < 5; i++) step();
        check("run5_score",  32'(bus.score),         32'd5);
        check("run5_period", 32'(bus.scroll_period), 32'd2);

        drive(1, 1);
        step();
        drive(1, 0);
        step();
        check("crash_over_pulse", 32'(bus.game_over_pulse), 32'd1);
        check("crash_running",    32'(bus.running),         32'd0);
        check("crash_score",      32'(bus.score),           32'd5);

        repeat (40) step();
        check("held_no_restart", 32'(bus.running), 32'd0);
        check("held_score",      32'(bus.score),   32'd5);

        drive(0, 0);
        repeat (3) step();
        drive(1, 0);
        step(); step();
        check("restart_pulse",  32'(bus.game_start_pulse), 32'd1);
        check("restart_score",  32'(bus.score),            32'd0);
        check("restart_period", 32'(bus.scroll_period),    32'd3);

        // Time the crash so it reaches the FSM on a scroll-completing frame edge.
        for (int i = 0; i < 200; i++) begin
            if (m_st == S_RUN && (cyc + 2) % FD == 0 && m_fcnt + 1 == m_period()) break;
            step();
        end
        saved = m_score;
        drive(1, 1);
        step();
        drive(1, 0);
        step();
        check("coinc_frame",  32'(bus.game_tick[1]),     32'd1);
        check("coinc_scroll", 32'(bus.game_tick[0]),     32'd0);
        check("coinc_over",   32'(bus.game_over_pulse),  32'd1);
        check("coinc_score",  32'(bus.score),            32'(saved));

        repeat (30) step();
        drive(0, 0);
        repeat (2) step();
        drive(1, 0);
        repeat (20) step();
        check("pre_reset_running", 32'(bus.running), 32'd1);

        drive(0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_running", 32'(bus.running),          32'd0);
        check("rst_score",   32'(bus.score),            32'd0);
        check("rst_period",  32'(bus.scroll_period),    32'd3);
        check("rst_start",   32'(bus.game_start_pulse), 32'd0);
        check("rst_over",    32'(bus.game_over_pulse),  32'd0);
        check("rst_ticks",   32'(bus.game_tick),        32'd0);

        for (int i = 0; i < 1500; i++) begin
            b = bus.start_btn;
            if ($urandom_range(7) == 0) b = ~b;
            drive(b, $urandom_range(59) == 0);
            reset = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller that sequences `player_controller` and the `button_debounce` instances. Generates the free-running frame tick, the accelerating scroll tick and the debounce sample strobe. Owns the IDLE/RUNNING/GAME_OVER state and the run score. Its tick, strobe and pulse outputs replace the tick and countdown-enable signals currently driven from dedicated input pins.

## Interface
- `FRAME_DIV`, default 200000: clk cycles per frame tick (≥2).
- `DEBOUNCE_DIV`, default 50000: clk cycles per `debounce_en` strobe (≥2).
- `BASE_PERIOD`, default 8: frame ticks per scroll tick at game start (≥`MIN_PERIOD`, ≤15).
- `MIN_PERIOD`, default 2: fastest scroll period in frame ticks (≥1).
- `SPEEDUP_TICKS`, default 64: scroll ticks between period decrements (≥1).
- `LOCKOUT_FRAMES`, default 60: frame ticks spent in GAME_OVER (≥1).
- `clk  input  1`: system clock; one clock domain.
- `reset  input  1`: synchronous, active-high reset.
- `start_btn  input  1`: debounced start/jump button, level.
- `crash  input  1`: collision flag from the obstacle block, level.
- `game_tick  output  2`: [1] = frame tick, [0] = scroll tick; one-cycle pulses.
- `debounce_en  output  1`: one-cycle strobe feeding the debouncers' `countdown_en`.
- `game_start_pulse  output  1`: one cycle on IDLE→RUNNING.
- `game_over_pulse  output  1`: one cycle on RUNNING→GAME_OVER.
- `running  output  1`: high while in RUNNING.
- `scroll_period  output  4`: current scroll period in frame ticks.
- `score  output  14`: scroll ticks survived in the current or last run.

## Operation
- Reset values: state IDLE, all pulses 0, `running` 0, `score` 0, `scroll_period` = `BASE_PERIOD`, all counters 0, button history 0.
- Frame and debounce dividers are free-running in every state.
  - Each counts 0..DIV-1 and pulses its output for the single cycle after the count reaches DIV-1.
- States:
  - IDLE: scroll tick held 0, score holds the last run's value. A `start_btn` rising edge (current=1, registered previous=0) moves to RUNNING.
  - RUNNING: counts frame ticks. When `scroll_cnt` = `scroll_period`-1 on a frame tick, it emits a scroll tick, clears `scroll_cnt` and increments `score`. `score` saturates at 16383.
  - GAME_OVER: scroll held 0, score frozen. Counts `LOCKOUT_FRAMES` frame ticks, then moves to IDLE.
- Entry to RUNNING, in the same edge: `score`←0, `scroll_period`←`BASE_PERIOD`, `scroll_cnt`←0, speed counter←0, `game_start_pulse`←1.
- Speed-up: every `SPEEDUP_TICKS`-th scroll tick decrements `scroll_period` by 1, floored at `MIN_PERIOD`.
- `crash` is sampled only in RUNNING. When it is high, the next state is GAME_OVER and `game_over_pulse` is 1.
- Simultaneous events:
  - Crash plus a scroll-tick condition: the crash wins; scroll tick suppressed, no score increment.
  - Button edge plus crash in IDLE: crash ignored, start taken.
  - Button held through GAME_OVER→IDLE: no start until it is released and pressed again (edge-only).
  - Button edges in RUNNING and GAME_OVER: ignored.
- `reset` mid-run: next cycle is the full reset state; no pulses are emitted on that edge.

## Timing
- All outputs are registered; no combinational input→output path.
- Frame tick: first asserted `FRAME_DIV` cycles after `reset` deasserts, then every `FRAME_DIV` cycles. `debounce_en` behaves the same way with `DEBOUNCE_DIV`.
- Scroll tick: asserted in the same cycle as the frame tick that completes the period.
- `score` and `scroll_period` update on the same edge as the scroll tick.
- Start latency: rising edge of `start_btn` sampled at edge N gives `game_start_pulse` and `running` high after edge N+1.
- Crash latency: `crash` sampled at edge N gives `game_over_pulse` high and `running` low after edge N+1.
- Lockout: IDLE is entered on the edge after the `LOCKOUT_FRAMES`-th frame tick observed in GAME_OVER.

## Structure
- Package `game_pkg`:
  - `game_state_t` enum: IDLE, RUNNING, GAME_OVER.
  - `SCORE_W`=14, `PERIOD_W`=4.
  - `SCORE_MAX`=14'h3FFF.
- Sub-module `tick_divider` (parameter `DIV`; ports `clk`, `reset`, `tick`). Instantiated twice: frame and debounce.
- FSM, scroll counter, speed counter, lockout counter and score live in `game_sequencer`.

## Test plan
All runs use FRAME_DIV=4, DEBOUNCE_DIV=6, BASE_PERIOD=3, MIN_PERIOD=2, SPEEDUP_TICKS=2, LOCKOUT_FRAMES=2.
- Reset release, idle 24 cycles -> `game_tick[1]` pulses at cycles 4,8,…,24 and `debounce_en` at 6,12,18,24. `game_tick[0]`=0, `score`=0, `scroll_period`=3.
- `start_btn` 0→1 -> `game_start_pulse` for exactly 1 cycle, `running`=1. Scroll ticks on every 3rd frame tick, then on every 2nd frame tick from the 2nd scroll tick on; `scroll_period` stops at 2.
- Run 5 scroll ticks, then assert `crash` -> `game_over_pulse` 1 cycle, `score`=5 and frozen. After 2 frame ticks the state is IDLE and `score` stays 5.
- Hold `start_btn`=1 continuously through GAME_OVER into IDLE -> no restart. Release, then press -> restart with `score`=0, `scroll_period`=3.
- Raise `crash` on the same cycle as a scroll-completing frame tick -> `game_tick[0]` stays 0, `score` not incremented, `game_over_pulse`=1.
- Assert `reset` for 1 cycle mid-RUNNING -> next cycle IDLE, `score`=0, `scroll_period`=3, no pulses.
